uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  Standalone UART receiver for the link driven by our uart_transmitter: frame = start(0), DATA_BITS
//  data LSB-first, optional even-parity bit, one stop(1). Resynchronises the async line, validates
//  the start bit at mid-bit, samples each bit at its centre, checks parity/stop, and hands each byte
//  to the consumer over a valid/ready handshake with error and overrun flags.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per bit; integer >= 4
//  DATA_BITS     8   data bits per frame; 5..9
//  PARITY_EN     1   1: even-parity bit after data; 0: no parity bit
// PORTS
//  clk         in   1          system clock, rising edge
//  rst         in   1          asynchronous, active-high reset
//  rx_in       in   1          serial line, async to clk, idles high
//  data_out    out  DATA_BITS  received byte, stable while data_valid=1
//  data_valid  out  1          received frame available
//  data_ready  in   1          consumer accepts data_out when high with data_valid
//  parity_err  out  1          parity mismatch in frame on data_out (0 if PARITY_EN=0)
//  frame_err   out  1          stop bit sampled 0 in frame on data_out
//  overrun     out  1          sticky: a frame was dropped because data_out was not consumed
//  busy        out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0; FSM->IDLE;
//   sync flops and previous-sample reg = 1. Reset mid-frame aborts the frame with no output.
//  Input: 2-flop synchroniser on rx_in -> rx_s; all decisions use rx_s (2-cycle input latency).
//  Counter cnt: 0..CLKS_PER_BIT-1; bit index idx: 0..DATA_BITS-1.
//  FSM:
//   IDLE   : on rx_s falling edge (prev=1, now=0) -> START, cnt=0. A continuously low line
//            (break) never retriggers; it must return high first.
//   START  : at cnt==CLKS_PER_BIT/2-1 sample rx_s; 1 -> false start, back to IDLE, nothing
//            reported; 0 -> cnt=0, idx=0, go DATA. All later samples are mid-bit.
//   DATA   : at cnt==CLKS_PER_BIT-1 shift rx_s into shreg MSB end (LSB-first), cnt=0; after
//            DATA_BITS samples -> PARITY if PARITY_EN else STOP.
//   PARITY : at cnt==CLKS_PER_BIT-1 sample p; perr = ^shreg ^ p (even parity: 0 = OK) -> STOP.
//   STOP   : at cnt==CLKS_PER_BIT-1 sample s; ferr = ~s; deliver frame; -> IDLE.
//  Delivery (cycle after stop sample): if data_valid==0, or data_valid&data_ready in that
//   same cycle: data_out<=shreg, parity_err<=perr, frame_err<=ferr, data_valid<=1.
//   Else (unconsumed data held): new frame discarded, overrun<=1, held data/flags unchanged.
//  Handshake: data_valid&data_ready -> data_valid=0 next cycle (unless a new frame loads in that
//   cycle); overrun clears on that accept. data_out/flags change only on load.
//  Errored frames are still delivered, with their flags; flags describe the frame on data_out.
//  Min latency stop-sample -> data_valid = 1 clk; line edge -> START entry = 3 clks.
// TESTING
//  T1 CLKS_PER_BIT=16, send 0xA5 (parity 0, stop 1), data_ready=1 -> one data_valid pulse,
//     data_out=8'hA5, parity_err=0, frame_err=0, overrun=0.
//  T2 send 0x01 with parity bit forced 0 -> data_out=8'h01, parity_err=1, frame_err=0.
//  T3 send 0x3C with stop bit forced 0, line held low 40 bit times -> data_out=8'h3C,
//     frame_err=1; no further frame until line high then next start; next 0x55 received clean.
//  T4 glitch: rx_in low 4 clks then high -> busy pulses, FSM back to IDLE, no data_valid.
//  T5 data_ready=0, send 0x11 then 0x22 -> data_out stays 8'h11, overrun=1; raise data_ready ->
//     data_valid drops, overrun=0; third frame 0x33 delivered normally.
//  T6 assert rst mid-DATA of 0x77, release, send 0x88 -> all outputs 0 during reset; only
//     data_out=8'h88 delivered, no error flags.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: start/data/even-parity/stop framing, mid-bit sampling,
// single-entry output register with valid/ready handshake, error and sticky overrun flags.
module uart_rx_oversampled #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 prev_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dv_q, dv_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;
    logic                 busy_q, busy_d;
    logic                 rx_s;
    logic                 frame_done_c;
    logic                 accept_c;

    assign rx_s = sync_q[1];

    // Registers: synchroniser, previous sample, FSM and output holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_in};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, bit sampling and delivery logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        frame_done_c = 1'b0;
        dout_d       = dout_q;
        dv_d         = dv_q;
        pe_d         = pe_q;
        fe_d         = fe_q;
        ov_d         = ov_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // Only a high-to-low transition starts a frame, so a held break is ignored.
                if (prev_q && !rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = (^shreg_q) ^ rx_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    frame_done_c = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        accept_c = dv_q && data_ready;
        if (accept_c) begin
            dv_d = 1'b0;
            ov_d = 1'b0;
        end
        // A finished frame loads only if the register is empty or being drained this cycle.
        if (frame_done_c) begin
            if (!dv_q || accept_c) begin
                dout_d = shreg_q;
                pe_d   = perr_q;
                fe_d   = ~rx_s;
                dv_d   = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Randomised bench for uart_rx_oversampled: frames are generated bit by bit and a
// frame-level model predicts every delivery, flag, overrun and busy window.
module tb_uart_rx_oversampled;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int PE    = 1;
    localparam int H     = CPB / 2;
    localparam int NBITS = 1 + DB + PE + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_in = 1'b1;
    logic          data_ready = 1'b1;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    uart_rx_oversampled #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .PARITY_EN   (PE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            dl;
        logic [DB-1:0] d;
        bit            pe;
        bit            fe;
    } frame_t;

    typedef struct {
        int from;
        int upto;
    } win_t;

    frame_t fq[$];
    win_t   wq[$];

    logic [DB-1:0] m_dout = '0;
    bit m_dv = 0, m_pe = 0, m_fe = 0, m_ov = 0, m_busy = 0;
    frame_t cf;
    logic [DB+4:0] exp_v, got_v;

    logic [DB-1:0] last_dout = '0;
    bit last_pe = 0, last_fe = 0, dv_prev = 0;
    int vpulses = 0;
    int busy_cycles = 0;

    bit rand_rdy = 0;
    bit rdy_fixed = 1;

    always @(posedge clk) begin
        #3;
        data_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end

    // Model update for the edge just taken, then whole-output comparison.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            fq.delete();
            wq.delete();
            m_dout = '0;
            m_dv = 0; m_pe = 0; m_fe = 0; m_ov = 0; m_busy = 0;
        end else begin
            if (m_dv && data_ready) begin
                m_dv = 0;
                m_ov = 0;
            end
            if (fq.size() > 0 && fq[0].dl == cyc) begin
                cf = fq.pop_front();
                if (!m_dv) begin
                    m_dout = cf.d;
                    m_pe   = cf.pe;
                    m_fe   = cf.fe;
                    m_dv   = 1;
                end else begin
                    m_ov = 1;
                end
            end
            while (wq.size() > 0 && wq[0].upto <= cyc) void'(wq.pop_front());
            m_busy = 0;
            foreach (wq[i]) if (wq[i].from <= cyc && cyc < wq[i].upto) m_busy = 1;
        end
        exp_v = {m_dv, m_dout, m_pe, m_fe, m_ov, m_busy};
        got_v = {data_valid, data_out, parity_err, frame_err, overrun, busy};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL cycle_check @%0d: dut dv=%b dout=%h pe=%b fe=%b ov=%b busy=%b, expected dv=%b dout=%h pe=%b fe=%b ov=%b busy=%b",
                     cyc, data_valid, data_out, parity_err, frame_err, overrun, busy,
                     m_dv, m_dout, m_pe, m_fe, m_ov, m_busy);
        end
        if (data_valid) begin
            last_dout = data_out;
            last_pe   = parity_err;
            last_fe   = frame_err;
        end
        if (data_valid && !dv_prev) vpulses++;
        dv_prev = data_valid;
        if (busy) busy_cycles++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic bit_hold(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge and schedules its delivery.
    task automatic send_frame(input logic [DB-1:0] d, input bit pflip, input bit sflip,
                              input int low_bits, input int gap_bits);
        int     t;
        logic   p;
        frame_t f;
        win_t   w;
        t    = cyc;
        p    = (^d) ^ pflip;
        f.dl = t + 3 + H + (NBITS - 1) * CPB;
        f.d  = d;
        f.pe = (^d) ^ p;
        f.fe = sflip;
        w.from = t + 3;
        w.upto = f.dl;
        fq.push_back(f);
        wq.push_back(w);
        bit_hold(1'b0, CPB);
        for (int i = 0; i < DB; i++) bit_hold(d[i], CPB);
        if (PE != 0) bit_hold(p, CPB);
        bit_hold(~sflip, CPB);
        if (low_bits > 0) bit_hold(1'b0, low_bits * CPB);
        bit_hold(1'b1, gap_bits * CPB);
    endtask

    task automatic glitch(input int len);
        win_t w;
        w.from = cyc + 3;
        w.upto = cyc + 3 + H;
        wq.push_back(w);
        bit_hold(1'b0, len);
        bit_hold(1'b1, CPB + H);
    endtask

    initial begin
        int p0, b0, t, gap, low;
        win_t w;
        logic [DB-1:0] d;
        bit pf, sf;

        repeat (3) @(negedge clk);
        chk("reset_state", 32'({data_out, data_valid, parity_err, frame_err, overrun, busy}), 32'(0));
        rst = 1'b0;
        bit_hold(1'b1, 2 * CPB);

        // Clean frame with consumer always ready.
        p0 = vpulses;
        send_frame(8'hA5, 0, 0, 0, 2);
        chk("t1_pulses", 32'(vpulses - p0), 32'(1));
        chk("t1_dout", 32'(last_dout), 32'h0000_00A5);
        chk("t1_model_dout", 32'(m_dout), 32'h0000_00A5);
        chk("t1_flags", 32'({last_pe, last_fe, overrun}), 32'(0));

        // Bad parity bit.
        send_frame(8'h01, 1, 0, 0, 2);
        chk("t2_dout", 32'(last_dout), 32'h0000_0001);
        chk("t2_flags", 32'({last_pe, last_fe}), 32'b10);

        // Bad stop bit followed by a long break, then a clean frame.
        p0 = vpulses;
        send_frame(8'h3C, 0, 1, 40, 2);
        chk("t3_dout", 32'(last_dout), 32'h0000_003C);
        chk("t3_flags", 32'({last_pe, last_fe}), 32'b01);
        chk("t3_no_retrigger", 32'(vpulses - p0), 32'(1));
        send_frame(8'h55, 0, 0, 0, 2);
        chk("t3_next_dout", 32'(last_dout), 32'h0000_0055);
        chk("t3_next_flags", 32'({last_pe, last_fe}), 32'(0));

        // Short glitch: false start only.
        p0 = vpulses;
        b0 = busy_cycles;
        glitch(4);
        chk("t4_busy_cycles", 32'(busy_cycles - b0), 32'(H));
        chk("t4_no_valid", 32'(vpulses - p0), 32'(0));
        chk("t4_idle", 32'(busy), 32'(0));

        // Overrun while the consumer stalls.
        rdy_fixed = 1'b0;
        bit_hold(1'b1, CPB);
        send_frame(8'h11, 0, 0, 0, 1);
        send_frame(8'h22, 0, 0, 0, 1);
        chk("t5_held", 32'({data_valid, data_out, overrun}), 32'({1'b1, 8'h11, 1'b1}));
        rdy_fixed = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_accepted", 32'({data_valid, overrun}), 32'(0));
        send_frame(8'h33, 0, 0, 0, 1);
        chk("t5_third", 32'({last_dout, overrun}), 32'({8'h33, 1'b0}));

        // Reset in the middle of a frame.
        t = cyc;
        w.from = t + 3;
        w.upto = 1 << 30;
        wq.push_back(w);
        bit_hold(1'b0, CPB);
        bit_hold(1'b1, 3 * CPB + H);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        chk("t6_in_reset", 32'({data_out, data_valid, parity_err, frame_err, overrun, busy}), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bit_hold(1'b1, 2 * CPB);
        p0 = vpulses;
        send_frame(8'h88, 0, 0, 0, 2);
        chk("t6_pulses", 32'(vpulses - p0), 32'(1));
        chk("t6_dout", 32'({last_dout, last_pe, last_fe}), 32'({8'h88, 2'b00}));

        // Random traffic, random back-pressure, occasional glitches and errors.
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, H - 2));
            d   = DB'($urandom);
            pf  = ($urandom_range(0, 5) == 0);
            sf  = ($urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 2);
            if (sf && gap == 0) gap = 1;
            low = (sf && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            send_frame(d, pf, sf, low, gap);
        end
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b1;
        bit_hold(1'b1, 4 * CPB);
        chk("all_frames_due", 32'(fq.size()), 32'(0));
        chk("final_idle", 32'({data_valid, busy}), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
